// File: rtl/sobel_pkg.sv
// Shared constants and types for the sobel_edge stage (default build: SOBEL_THRESH_EN undefined).
package sobel_pkg;

  localparam int COLORDEPTH_DEF = 8;
  localparam int GRAD_GROWTH    = 3;   // GRAD_W = COLORDEPTH + 3
  localparam int MAG_GROWTH     = 4;   // MAG_W  = COLORDEPTH + 4
  localparam int GRAD_W         = COLORDEPTH_DEF + GRAD_GROWTH;
  localparam int MAG_W          = COLORDEPTH_DEF + MAG_GROWTH;
  localparam int PIPE_LAT       = 5;

  // Kernel weights are 1 (edge taps) and 2 (middle tap, applied as a shift).
  localparam int K_EDGE      = 1;
  localparam int K_MID_SHIFT = K_EDGE;

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
    logic le;
  } sync_t;

  function automatic int sat_max(input int colordepth);
    return (1 << colordepth) - 1;
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// One line of pixel storage: shared address, registered read-before-write, plus the
// pre-write word so a second RAM can be cascaded behind this one.
module sobel_line_ram #(
  parameter int DEPTH  = 1600,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  old_o,
  output logic [WIDTH-1:0]  rd_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign old_o = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      rd_q      <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_edge.sv
// Sobel edge magnitude: two-line buffer, 3x3 window, 5-stage gradient pipeline and
// matching sideband delay. `define SOBEL_THRESH_EN for a binary edge map against thr_i.
module sobel_edge
  import sobel_pkg::*;
#(
  parameter int COLORDEPTH  = COLORDEPTH_DEF,
  parameter int SCREENWIDTH = 1600
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLORDEPTH-1:0] data_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  line_end_i,
`ifdef SOBEL_THRESH_EN
  input  logic [COLORDEPTH-1:0] thr_i,
`endif
  output logic [COLORDEPTH-1:0] sob_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  line_end_o
);

  localparam int GW = COLORDEPTH + GRAD_GROWTH;
  localparam int MW = COLORDEPTH + MAG_GROWTH;
  localparam int CW = $clog2(SCREENWIDTH);
  localparam logic [CW-1:0] COL_MAX = CW'(SCREENWIDTH - 1);

  function automatic logic signed [GW-1:0] ext(input logic [COLORDEPTH-1:0] v);
    return $signed({{(GW-COLORDEPTH){1'b0}}, v});
  endfunction

  sync_t sync_in;
  sync_t [PIPE_LAT-1:0] dly_q, dly_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [COLORDEPTH-1:0] pix_q, pix_d;
  logic [3:0] brd_q, brd_d;
  logic [2:0][2:0][COLORDEPTH-1:0] win_q, win_d;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [GW-1:0] ax, ay;
  logic [MW-1:0] mag_q, mag_d;
  logic [COLORDEPTH-1:0] lvl, sob_q, sob_d;
  logic [COLORDEPTH-1:0] l1_old, l1_q, l2_q, l2_old_unused;

  assign sync_in = '{dv: dv_i, hs: hs_i, vs: vs_i, le: line_end_i};

  // L1 holds the previous line; L2 receives whatever L1 held at the same column.
  sobel_line_ram #(.DEPTH(SCREENWIDTH), .WIDTH(COLORDEPTH), .ADDR_W(CW)) u_l1 (
    .clk(clk), .addr(col_q), .we(dv_i), .wdata(data_i), .old_o(l1_old), .rd_q(l1_q)
  );
  sobel_line_ram #(.DEPTH(SCREENWIDTH), .WIDTH(COLORDEPTH), .ADDR_W(CW)) u_l2 (
    .clk(clk), .addr(col_q), .we(dv_i), .wdata(l1_old), .old_o(l2_old_unused), .rd_q(l2_q)
  );

  always_comb begin
    col_d = col_q;
    if (line_end_i || hs_i)               col_d = '0;
    else if (dv_i && (col_q != COL_MAX))  col_d = col_q + 1'b1;

    row_d = row_q;
    if (vs_i)                             row_d = '0;
    else if (line_end_i && (row_q != 2'd2)) row_d = row_q + 1'b1;

    pix_d = dv_i ? data_i : pix_q;
    brd_d = {brd_q[2:0], (row_q < 2'd2) || (col_q < CW'(2))};
    dly_d = {dly_q[PIPE_LAT-2:0], sync_in};

    // Window advances only when the RAM outputs and pixel register hold a new column.
    win_d = win_q;
    if (dly_q[0].dv) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = l2_q;
      win_d[1][2] = l1_q;
      win_d[2][2] = pix_q;
    end

    gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< K_MID_SHIFT) + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< K_MID_SHIFT) + ext(win_q[2][0]));
    gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< K_MID_SHIFT) + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< K_MID_SHIFT) + ext(win_q[0][2]));

    ax    = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay    = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag_d = {{(MW-GW){1'b0}}, ax} + {{(MW-GW){1'b0}}, ay};

`ifdef SOBEL_THRESH_EN
    lvl = (mag_q >= {{(MW-COLORDEPTH){1'b0}}, thr_i}) ? '1 : '0;
`else
    lvl = (mag_q > MW'(sat_max(COLORDEPTH))) ? '1 : mag_q[COLORDEPTH-1:0];
`endif
    sob_d = (dly_q[3].dv && !brd_q[3]) ? lvl : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      pix_q <= '0;
      brd_q <= '0;
      dly_q <= '0;
      win_q <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      mag_q <= '0;
      sob_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      pix_q <= pix_d;
      brd_q <= brd_d;
      dly_q <= dly_d;
      win_q <= win_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      mag_q <= mag_d;
      sob_q <= sob_d;
    end
  end

  assign sob_o      = sob_q;
  assign dv_o       = dly_q[PIPE_LAT-1].dv;
  assign hs_o       = dly_q[PIPE_LAT-1].hs;
  assign vs_o       = dly_q[PIPE_LAT-1].vs;
  assign line_end_o = dly_q[PIPE_LAT-1].le;

endmodule
